// File: rtl/seq_multiplier_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_param_pkg
//  Description : Shared types and constants for the sequential shift-add
//                multiplier: controller state encoding, common literals and
//                a constant-evaluable ceil(log2) used to size the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_multiplier_param_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    localparam int   ONE      = 1;
    localparam int   ZERO     = 0;
    localparam logic BIT_ZERO = 1'b0;
    localparam logic BIT_ONE  = 1'b1;

    // ceil(log2(value)); callers guarantee value >= 2 so the result is >= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_sign_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_sign_unit
//  Description : Combinational sign handling for the sequential multiplier.
//                Converts operands to magnitudes, derives the result sign,
//                and applies the final conditional 2*DW-bit negation.
//  Ports       : is_signed - operands are 2's complement
//                op_a/op_b - raw operands (DW bits)
//                acc       - unsigned magnitude product (2*DW bits)
//                neg_in    - latched result sign used for final negation
//                mag_a/b   - operand magnitudes (DW bits, unsigned)
//                neg       - sign of the product for the current operands
//                result    - acc, or -acc when neg_in is set
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_sign_unit #(
    parameter int DW = 16
) (
    input  logic            is_signed,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    input  logic [2*DW-1:0] acc,
    input  logic            neg_in,
    output logic [DW-1:0]   mag_a,
    output logic [DW-1:0]   mag_b,
    output logic            neg,
    output logic [2*DW-1:0] result
);
    import seq_multiplier_param_pkg::*;

    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = (is_signed == BIT_ONE) && op_a[DW-1];
    assign w_b_neg = (is_signed == BIT_ONE) && op_b[DW-1];

    // -2^(DW-1) negates to itself in DW bits, which read unsigned is exactly
    // its magnitude, so no special case is required.
    assign mag_a  = w_a_neg ? -op_a : op_a;
    assign mag_b  = w_b_neg ? -op_b : op_b;
    assign neg    = w_a_neg ^ w_b_neg;
    assign result = neg_in ? -acc : acc;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_param
//  Description : Parametrised shift-add multiplier with start/busy/done
//                handshake, runtime signed/unsigned mode and optional early
//                termination once the remaining multiplier bits are zero.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                start      - begin an operation (accepted in IDLE/DONE)
//                clr        - synchronous abort/clear, wins over start
//                is_signed  - operands are 2's complement (sampled on start)
//                op_a       - multiplicand (sampled on start)
//                op_b       - multiplier (sampled on start)
//                busy       - high while iterating or applying the sign
//                done       - level, high until next accepted start or clr
//                product    - last result, updated only when finishing
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_param #(
    parameter int DW         = 16,
    parameter int EARLY_EXIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clr,
    input  logic            is_signed,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);
    import seq_multiplier_param_pkg::*;

    localparam int            CW         = clog2(DW);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DW - 1);

    mult_state_e     r_state;
    mult_state_e     w_state_next;

    logic [2*DW-1:0] r_mcand;
    logic [DW-1:0]   r_mplier;
    logic [2*DW-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic [2*DW-1:0] r_product;

    logic            w_accept;
    logic            w_last;
    logic [DW-1:0]   w_mplier_shift;
    logic [DW-1:0]   w_mag_a;
    logic [DW-1:0]   w_mag_b;
    logic            w_neg;
    logic [2*DW-1:0] w_result;

    seq_mult_sign_unit #(
        .DW(DW)
    ) u_sign (
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc       (r_acc),
        .neg_in    (r_neg),
        .mag_a     (w_mag_a),
        .mag_b     (w_mag_b),
        .neg       (w_neg),
        .result    (w_result)
    );

    assign w_mplier_shift = r_mplier >> 1;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = BIT_ZERO;
        w_last       = BIT_ZERO;
        busy         = BIT_ZERO;
        done         = BIT_ZERO;

        // The current iteration is the last one either by count or, with
        // early exit, when nothing but zeros is left to shift in.
        if ((r_cnt == c_CNT_LAST) ||
            ((EARLY_EXIT == ONE) && (w_mplier_shift == '0))) begin
            w_last = BIT_ONE;
        end

        case (r_state)
            IDLE: begin
                if (start && !clr) begin
                    w_accept     = BIT_ONE;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = BIT_ONE;
                if (w_last) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                busy         = BIT_ONE;
                w_state_next = DONE;
            end
            DONE: begin
                done = BIT_ONE;
                if (start && !clr) begin
                    w_accept     = BIT_ONE;
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (clr) begin
            w_state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= BIT_ZERO;
            r_product <= '0;
        end else if (clr) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= BIT_ZERO;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{DW{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_cnt    <= CW'(ZERO);
        end else if (r_state == RUN) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
            r_cnt    <= r_cnt + CW'(ONE);
        end else if (r_state == FIX) begin
            r_product <= w_result;
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier_param
//  Description : Self-checking bench for seq_multiplier_param, DW=8, with one
//                instance per EARLY_EXIT setting sharing operand inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_param;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic          is_signed = 1'b0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;

    logic            busy0, done0, busy1, done1;
    logic [2*DW-1:0] prod0, prod1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [2*DW-1:0] last0 = '0;
    logic [2*DW-1:0] last1 = '0;

    seq_multiplier_param #(.DW(DW), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .clr(clr), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0), .product(prod0)
    );

    seq_multiplier_param #(.DW(DW), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .clr(clr), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1), .product(prod1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s %s: observed %0h, expected %0h", tag, what, obs, exp);
        end
    endtask

    // Reference: the mathematical product, truncated to 2*DW bits.
    function automatic logic [2*DW-1:0] model_prod(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b,
                                                   input bit s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[2*DW-1:0];
    endfunction

    // Reference: edges from the start edge until done is seen.
    function automatic int model_lat(input bit ee, input logic [DW-1:0] b, input bit s);
        int mb;
        int k;
        if (!ee) return DW + 1;
        mb = int'(b);
        if (s && b[DW-1]) mb = (1 << DW) - int'(b);
        k = 0;
        for (int i = 0; i < DW; i++) begin
            if (mb[i]) k = i;
        end
        return k + 2;
    endfunction

    task automatic sample(input bit ee, output logic d, output logic bz,
                          output logic [2*DW-1:0] p);
        d  = ee ? done1 : done0;
        bz = ee ? busy1 : busy0;
        p  = ee ? prod1 : prod0;
    endtask

    // One operation; repulse > 0 re-pulses start (2*2) so that it is
    // sampled on that edge counted from the accepting edge.
    task automatic do_op(input bit ee, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit s, input int repulse, input string tag);
        int              edges;
        logic            held;
        logic            busy_ok;
        logic            d, bz;
        logic [2*DW-1:0] p;
        logic [2*DW-1:0] prev;
        prev = ee ? last1 : last0;
        @(negedge clk);
        op_a = a; op_b = b; is_signed = s;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        edges = 0; held = 1'b1; busy_ok = 1'b1;
        sample(ee, d, bz, p);
        while (!d && edges < 40) begin
            if (p !== prev) held = 1'b0;
            if (bz !== 1'b1) busy_ok = 1'b0;
            if (edges == repulse - 1) begin
                @(negedge clk);
                op_a = 8'd2; op_b = 8'd2; is_signed = 1'b1;
                if (ee) start1 = 1'b1; else start0 = 1'b1;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            edges++;
            sample(ee, d, bz, p);
        end
        check(tag, "latency", edges, model_lat(ee, b, s));
        check(tag, "product", p, model_prod(a, b, s));
        check(tag, "held", held, 1);
        check(tag, "busy_run", busy_ok, 1);
        check(tag, "busy_done", bz, 0);
        if (ee) last1 = model_prod(a, b, s); else last0 = model_prod(a, b, s);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset", "busy0", busy0, 0);
        check("reset", "done0", done0, 0);
        check("reset", "prod0", prod0, 0);
        check("reset", "busy1", busy1, 0);
        check("reset", "done1", done1, 0);
        check("reset", "prod1", prod1, 0);
        @(negedge clk); rst = 1'b1;

        // Fixed-latency directed cases
        do_op(1'b0, 8'd200, 8'd255, 1'b0, 0, "u200x255");
        check("u200x255", "const", prod0, 16'hC738);
        do_op(1'b0, 8'h80, 8'h80, 1'b1, 0, "s-128x-128");
        check("s-128x-128", "const", prod0, 16'h4000);
        do_op(1'b0, 8'h80, 8'h7F, 1'b1, 0, "s-128x127");
        check("s-128x127", "const", prod0, 16'hC080);
        do_op(1'b0, 8'd7, 8'hFD, 1'b1, 0, "s7x-3");
        check("s7x-3", "const", prod0, 16'hFFEB);
        do_op(1'b0, 8'h80, 8'h80, 1'b0, 0, "u80x80");
        check("u80x80", "const", prod0, 16'h4000);

        // Early exit
        do_op(1'b1, 8'd9, 8'd0, 1'b0, 0, "ee9x0");
        do_op(1'b1, 8'd3, 8'd5, 1'b0, 0, "ee3x5");
        do_op(1'b1, 8'd3, 8'h80, 1'b0, 0, "ee3x80");
        do_op(1'b1, 8'hFF, 8'hFF, 1'b1, 0, "ee-1x-1");

        // Start re-pulse while running is ignored
        do_op(1'b0, 8'd12, 8'd10, 1'b0, 3, "restart");
        check("restart", "const", prod0, 16'd120);

        // clr on edge 4 of an operation
        @(negedge clk);
        op_a = 8'd9; op_b = 8'd9; is_signed = 1'b0; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        check("clr", "busy", busy0, 0);
        check("clr", "done", done0, 0);
        check("clr", "product", prod0, 0);
        last0 = '0;

        // Asynchronous reset mid-run
        do_op(1'b0, 8'd11, 8'd13, 1'b0, 0, "pre_rst");
        @(negedge clk);
        op_a = 8'd3; op_b = 8'd3; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst", "busy0", busy0, 0);
        check("arst", "done0", done0, 0);
        check("arst", "prod0", prod0, 0);
        check("arst", "done1", done1, 0);
        check("arst", "prod1", prod1, 0);
        @(negedge clk); rst = 1'b1;
        last0 = '0; last1 = '0;

        // Back-to-back: second start accepted in the DONE cycle
        do_op(1'b0, 8'd5, 8'd5, 1'b0, 0, "b2b_first");
        do_op(1'b0, 8'd6, 8'd7, 1'b0, 0, "b2b_second");
        check("b2b", "const", prod0, 16'd42);

        // clr and start together from DONE: clr wins
        @(negedge clk); clr = 1'b1; start0 = 1'b1; op_a = 8'd4; op_b = 8'd4;
        @(posedge clk); #1; clr = 1'b0; start0 = 1'b0;
        check("clr_start", "busy", busy0, 0);
        check("clr_start", "done", done0, 0);
        check("clr_start", "product", prod0, 0);
        @(posedge clk); #1;
        check("clr_start", "idle_busy", busy0, 0);
        check("clr_start", "idle_done", done0, 0);
        last0 = '0;

        // Randomised operations on both instances
        for (int i = 0; i < 24; i++) begin
            logic [DW-1:0] ra, rb;
            bit            rs;
            ra = DW'($urandom);
            rb = DW'($urandom);
            if (i % 6 == 5) rb = DW'($urandom_range(0, 3));
            rs = bit'($urandom_range(0, 1));
            do_op(bit'(i % 2), ra, rb, rs, 0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
